// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared FSM state encoding and counter sizing for serial_adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter needs at least one bit even when a single digit covers the word.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================================
// Module   : serial_adder_if
// Brief    : Operand/result handshake bundle between a requester and serial_adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/fa_slice.sv
// ============================================================================
// Module   : fa_slice
// Brief    : Combinational ripple of DIGIT full-adder cells for one digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fa_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic w_c;

  always_comb begin
    o_sum  = '0;
    o_cmsb = 1'b0;
    w_c    = i_cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        o_cmsb = w_c;
      end
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (i_a[i] & w_c) | (i_b[i] & w_c);
    end
    o_cout = w_c;
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Digit-serial adder/subtractor with start/busy/done and signed ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int              c_N    = WIDTH / DIGIT;
  localparam int              c_CW   = cnt_width(c_N);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_last;
  logic              w_busy;
  logic              w_done;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  w_a_next;
  logic              r_carry;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [DIGIT-1:0]  w_slice_sum;
  logic              w_slice_cout;
  logic              w_slice_cmsb;

  fa_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout),
    .o_cmsb (w_slice_cmsb)
  );

  // r_a doubles as the result accumulator: consumed digits leave at the bottom
  // while sum digits enter at the top, so after N shifts it holds the result.
  if (c_N == 1) begin : g_single_digit
    assign w_a_next = w_slice_sum;
  end else begin : g_multi_digit
    assign w_a_next = {w_slice_sum, r_a[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_done = (r_state == DONE);
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_LAST) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= w_a_next;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + c_CW'(1);
      if (w_last) begin
        r_sum  <= w_a_next;
        r_cout <= w_slice_cout;
        r_ovf  <= w_slice_cmsb ^ w_slice_cout;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed-vector and corner-sequence bench for serial_adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] t_a = '0;
  logic [15:0] t_b = '0;
  logic        t_cin = 1'b0;
  logic        t_sub = 1'b0;
  logic [3:0]  t_start = '0;
  int          sel = 0;

  logic        m_busy, m_done, m_cout, m_ovf;
  logic [15:0] m_sum;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // 0: W8/D1   1: W16/D4   2: W4/D2   3: W8/D8
  serial_adder_if #(.WIDTH(8))  if8  ();
  serial_adder_if #(.WIDTH(16)) if16 ();
  serial_adder_if #(.WIDTH(4))  if4  ();
  serial_adder_if #(.WIDTH(8))  ifw  ();

  assign if8.start  = t_start[0];
  assign if8.sub    = t_sub;
  assign if8.cin    = t_cin;
  assign if8.a      = t_a[7:0];
  assign if8.b      = t_b[7:0];
  assign if16.start = t_start[1];
  assign if16.sub   = t_sub;
  assign if16.cin   = t_cin;
  assign if16.a     = t_a;
  assign if16.b     = t_b;
  assign if4.start  = t_start[2];
  assign if4.sub    = t_sub;
  assign if4.cin    = t_cin;
  assign if4.a      = t_a[3:0];
  assign if4.b      = t_b[3:0];
  assign ifw.start  = t_start[3];
  assign ifw.sub    = t_sub;
  assign ifw.cin    = t_cin;
  assign ifw.a      = t_a[7:0];
  assign ifw.b      = t_b[7:0];

  serial_adder #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  serial_adder #(.WIDTH(4),  .DIGIT(2)) dut4  (.clk(clk), .rst(rst), .bus(if4));
  serial_adder #(.WIDTH(8),  .DIGIT(8)) dutw  (.clk(clk), .rst(rst), .bus(ifw));

  always_comb begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
    m_sum  = '0;
    case (sel)
      0: begin m_busy = if8.busy;  m_done = if8.done;  m_cout = if8.cout;  m_ovf = if8.ovf;  m_sum = {8'h00, if8.sum};  end
      1: begin m_busy = if16.busy; m_done = if16.done; m_cout = if16.cout; m_ovf = if16.ovf; m_sum = if16.sum;           end
      2: begin m_busy = if4.busy;  m_done = if4.done;  m_cout = if4.cout;  m_ovf = if4.ovf;  m_sum = {12'h000, if4.sum}; end
      default: begin m_busy = ifw.busy; m_done = ifw.done; m_cout = ifw.cout; m_ovf = ifw.ovf; m_sum = {8'h00, ifw.sum}; end
    endcase
  end

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Launch one operation on DUT s and wait (bounded) for its done pulse.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output logic [15:0] sum, output logic cout, output logic ovf,
                        output int lat, output int nbusy);
    sel        = s;
    t_a        = a;
    t_b        = b;
    t_cin      = cin;
    t_sub      = sub;
    t_start[s] = 1'b1;
    tick();
    t_start[s] = 1'b0;
    t_a        = ~a;
    t_b        = ~b;
    t_cin      = ~cin;
    t_sub      = ~sub;
    lat        = 0;
    nbusy      = 0;
    while (!m_done && lat < 64) begin
      if (m_busy) nbusy++;
      tick();
      lat++;
    end
    sum  = m_sum;
    cout = m_cout;
    ovf  = m_ovf;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [12];
    logic [15:0] r_sum;
    logic        r_cout, r_ovf;
    int          lat, nbusy;
    int          d_cnt;
    int          d_at [8];
    logic        seen;

    vecs[0]  = '{1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset_state[%0d]", s), {m_busy, m_done, m_cout, m_ovf, m_sum}, 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      run_op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin, vecs[i].sub,
             r_sum, r_cout, r_ovf, lat, nbusy);
      chk($sformatf("vec%0d_sum", i),   r_sum,  {24'h0, vecs[i].sum});
      chk($sformatf("vec%0d_cout", i),  r_cout, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i),   r_ovf,  vecs[i].ovf);
      chk($sformatf("vec%0d_lat", i),   lat,    8);
      chk($sformatf("vec%0d_busy", i),  nbusy,  8);
      tick();
      chk($sformatf("vec%0d_done_width", i), m_done, 1'b0);
    end

    run_op(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, r_sum, r_cout, r_ovf, lat, nbusy);
    chk("w16_sum",  r_sum, 16'h0000);
    chk("w16_cout", r_cout, 1'b1);
    chk("w16_ovf",  r_ovf, 1'b0);
    chk("w16_lat",  lat, 4);
    chk("w16_busy", nbusy, 4);

    run_op(3, 16'h0064, 16'h001C, 1'b0, 1'b0, r_sum, r_cout, r_ovf, lat, nbusy);
    chk("n1_add", {lat[3:0], nbusy[3:0], r_cout, r_ovf, r_sum[7:0]}, {4'd1, 4'd1, 1'b0, 1'b1, 8'h80});
    run_op(3, 16'h0003, 16'h0005, 1'b0, 1'b1, r_sum, r_cout, r_ovf, lat, nbusy);
    chk("n1_sub", {lat[3:0], nbusy[3:0], r_cout, r_ovf, r_sum[7:0]}, {4'd1, 4'd1, 1'b0, 1'b0, 8'hFE});
    tick();

    // start pulsed mid-operation with new operands must be ignored
    sel = 0; t_a = 16'h005A; t_b = 16'h003C; t_cin = 1'b0; t_sub = 1'b0;
    t_start[0] = 1'b1;
    tick();
    t_start[0] = 1'b0; t_a = '0; t_b = '0;
    lat = 0;
    tick(); lat++;
    tick(); lat++;
    chk("ign_busy3", m_busy, 1'b1);
    t_start[0] = 1'b1; t_a = 16'h0001; t_b = 16'h0001;
    tick(); lat++;
    t_start[0] = 1'b0;
    while (!m_done && lat < 64) begin
      tick();
      lat++;
    end
    chk("ign_lat", lat, 8);
    chk("ign_sum", m_sum, 16'h0096);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (m_done || m_sum !== 16'h0096) seen = 1'b1;
    end
    chk("ign_no_second_update", seen, 1'b0);

    // reset during busy cycle 4 aborts without a done pulse
    t_a = 16'h00FF; t_b = 16'h0001;
    t_start[0] = 1'b1;
    tick();
    t_start[0] = 1'b0;
    repeat (3) tick();
    chk("rst_busy4", m_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outputs", {m_busy, m_done, m_cout, m_ovf, m_sum}, 32'h0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (m_done || m_busy) seen = 1'b1;
    end
    chk("rst_no_done", seen, 1'b0);

    rst = 1'b1; t_start[0] = 1'b1;
    tick();
    rst = 1'b0; t_start[0] = 1'b0;
    chk("rst_over_start", m_busy, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (m_done) seen = 1'b1;
    end
    chk("rst_over_start_no_done", seen, 1'b0);

    // start held high: one result every N+1 cycles
    t_a = 16'h0001; t_b = 16'h0001; t_cin = 1'b0; t_sub = 1'b0;
    t_start[0] = 1'b1;
    tick();
    d_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (m_done) begin
        if (d_cnt < 8) d_at[d_cnt] = c;
        d_cnt++;
        chk("b2b_sum", m_sum, 16'h0002);
      end
    end
    t_start[0] = 1'b0;
    chk("b2b_count", d_cnt, 4);
    chk("b2b_first", d_at[0], 8);
    chk("b2b_gap1", d_at[1] - d_at[0], 9);
    chk("b2b_gap2", d_at[2] - d_at[1], 9);
    chk("b2b_gap3", d_at[3] - d_at[2], 9);
    repeat (12) tick();

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int m = 0; m < 4; m++) begin
          logic [3:0] a4, b4, bb;
          logic       ci, xsub, xcin, eo;
          logic [4:0] full;
          logic [3:0] low;
          a4   = 4'(ia);
          b4   = 4'(ib);
          xcin = m[0];
          xsub = m[1];
          bb   = xsub ? ~b4 : b4;
          ci   = xsub ? 1'b1 : xcin;
          full = {1'b0, a4} + {1'b0, bb} + {4'b0, ci};
          low  = {1'b0, a4[2:0]} + {1'b0, bb[2:0]} + {3'b0, ci};
          eo   = low[3] ^ full[4];
          run_op(2, {12'h0, a4}, {12'h0, b4}, xcin, xsub, r_sum, r_cout, r_ovf, lat, nbusy);
          chk($sformatf("exh a=%0h b=%0h cin=%0b sub=%0b", a4, b4, xcin, xsub),
              {lat[3:0], nbusy[3:0], r_cout, r_ovf, r_sum[3:0]},
              {4'd2, 4'd2, full[4], eo, full[3:0]});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
